// File: rtl/f32_pkg.sv
// Shared FP32 definitions: sequencer states, field constants and classifiers,
// used by the divider and the multiplier.
package f32_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    DIVIDE,
    NORMALIZE,
    DONE
  } f32_seq_state_t;

  localparam int          F32_BIAS    = 127;
  localparam int          F32_EXP_W   = 8;
  localparam int          F32_FRAC_W  = 23;
  localparam logic [7:0]  F32_EXP_MAX = 8'hFF;
  localparam logic [31:0] F32_QNAN    = 32'h7FC0_0000;

  // Denormals are flushed, so a zero exponent alone means zero.
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == F32_EXP_MAX) && (x[22:0] == 23'h0);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == F32_EXP_MAX) && (x[22:0] != 23'h0);
  endfunction

endpackage

// File: rtl/f32_mant_div.sv
// Iterative restoring divider for 24-bit normalised mantissas; produces one
// quotient bit per cycle, MSB first, QBITS bits in total.
module f32_mant_div #(
  parameter int QBITS = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [23:0]      m_a_i,
  input  logic [23:0]      m_b_i,
  output logic             busy_o,
  output logic             last_o,
  output logic             valid_o,
  output logic [QBITS-1:0] q_o
);

  localparam int CW = $clog2(QBITS);

  logic [24:0]      rem_q, rem_d, rem_keep;
  logic [23:0]      m_b_q;
  logic [QBITS-1:0] q_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, valid_q;
  logic             ge;

  // NOTE: every always_comb output gets a default/full assignment up front so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    ge       = rem_q >= {1'b0, m_b_q};
    rem_keep = ge ? (rem_q - {1'b0, m_b_q}) : rem_q;
    // After a restore rem < m_b < 2^24, so the shift never loses a bit.
    rem_d    = {rem_keep[23:0], 1'b0};
  end

  // NOTE: sequential state uses non-blocking (<=) so all registers update from
  // pre-edge values; blocking (=) here would create ordering-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      m_b_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      rem_q   <= {1'b0, m_a_i};
      m_b_q   <= m_b_i;
      q_q     <= '0;
      cnt_q   <= CW'(QBITS - 1);
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
    end else if (busy_q) begin
      rem_q <= rem_d;
      q_q   <= {q_q[QBITS-2:0], ge};
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_q  <= 1'b0;
        valid_q <= 1'b1;
      end
    end
  end

  assign busy_o  = busy_q;
  assign last_o  = busy_q && (cnt_q == '0);
  assign valid_o = valid_q;
  assign q_o     = q_q;

endmodule

// File: rtl/f32_div.sv
// Multi-cycle IEEE-754 single-precision divider p = a / b with start/done
// handshake, flush-to-zero inputs and truncated (unrounded) results.
module f32_div
  import f32_pkg::*;
#(
  parameter int BIAS  = F32_BIAS,
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  output logic        done,
  output logic [31:0] p
);

  f32_seq_state_t state_q;
  logic [31:0]    a_q, b_q, p_q, spec_p_q;
  logic           sign_q, special_q, done_q;
  logic signed [9:0] exp_q;

  logic             div_load, div_busy, div_last, div_valid;
  logic [QBITS-1:0] div_q;
  logic             unused_div_status;

  logic              s_comb, special_comb;
  logic [31:0]       spec_p_comb, norm_p;
  logic signed [9:0] exp_diff, e_norm;
  logic [22:0]       frac_norm;

  assign div_load          = (state_q == UNPACK);
  assign unused_div_status = ^{div_busy, div_valid};

  f32_mant_div #(.QBITS(QBITS)) u_mant_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (div_load),
    .m_a_i   ({1'b1, a_q[22:0]}),
    .m_b_i   ({1'b1, b_q[22:0]}),
    .busy_o  (div_busy),
    .last_o  (div_last),
    .valid_o (div_valid),
    .q_o     (div_q)
  );

  always_comb begin
    s_comb       = a_q[31] ^ b_q[31];
    exp_diff     = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
                 + $signed(10'(BIAS));
    special_comb = 1'b1;
    spec_p_comb  = F32_QNAN;
    if (is_nan(a_q) || is_nan(b_q) || (is_zero(a_q) && is_zero(b_q)) ||
        (is_inf(a_q) && is_inf(b_q)))
      spec_p_comb = F32_QNAN;
    else if (is_inf(a_q))  spec_p_comb = {s_comb, F32_EXP_MAX, 23'h0};
    else if (is_inf(b_q))  spec_p_comb = {s_comb, 31'h0};
    else if (is_zero(b_q)) spec_p_comb = {s_comb, F32_EXP_MAX, 23'h0};
    else if (is_zero(a_q)) spec_p_comb = {s_comb, 31'h0};
    else                   special_comb = 1'b0;
  end

  // Mantissa ratio lies in (0.5, 2): bit QBITS-1 selects the binade.
  always_comb begin
    if (div_q[QBITS-1]) begin
      e_norm    = exp_q;
      frac_norm = div_q[QBITS-2 -: F32_FRAC_W];
    end else begin
      e_norm    = exp_q - 10'sd1;
      frac_norm = div_q[QBITS-3 -: F32_FRAC_W];
    end
    if (e_norm >= 10'sd255)    norm_p = {sign_q, F32_EXP_MAX, 23'h0};
    else if (e_norm <= 10'sd0) norm_p = {sign_q, 31'h0};
    else                       norm_p = {sign_q, e_norm[7:0], frac_norm};
  end

  // Specials skip DIVIDE but still pass through NORMALIZE, so p is only ever
  // written on the edge entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      spec_p_q  <= '0;
      sign_q    <= 1'b0;
      special_q <= 1'b0;
      exp_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            state_q <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q    <= s_comb;
          exp_q     <= exp_diff;
          special_q <= special_comb;
          spec_p_q  <= spec_p_comb;
          state_q   <= special_comb ? NORMALIZE : DIVIDE;
        end
        DIVIDE: begin
          if (div_last) state_q <= NORMALIZE;
        end
        NORMALIZE: begin
          p_q     <= special_q ? spec_p_q : norm_p;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done = done_q;
  assign p    = p_q;

endmodule
